// File: rtl/ddr_burst_arbiter.sv
// DDR burst arbiter: grants one write or read burst at a time to the memory port,
// paces write-FIFO reads through a one-word holding register and forwards read data.
module ddr_burst_arbiter (
  input  logic        clk_ref,
  input  logic        rst,
  input  logic        ddr_init_done,
  input  logic        ddr_wr_req,
  input  logic        ddr_rd_req,
  input  logic [24:0] ddr_wraddr,
  input  logic [24:0] ddr_rdaddr,
  input  logic [9:0]  wr_length,
  input  logic [9:0]  rd_length,
  output logic        ddr_wr_ack,
  input  logic [31:0] ddr_din,
  output logic        ddr_rd_ack,
  output logic [31:0] ddr_dout,
  output logic        ddr_wr_finish,
  output logic        ddr_rd_finish,
  output logic        mem_cmd_valid,
  input  logic        mem_cmd_ready,
  output logic        mem_cmd_we,
  output logic [24:0] mem_cmd_addr,
  output logic [9:0]  mem_cmd_len,
  output logic        mem_wdata_valid,
  input  logic        mem_wdata_ready,
  output logic [31:0] mem_wdata,
  input  logic        mem_rdata_valid,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    WR_CMD,
    WR_DATA,
    WR_DONE,
    RD_CMD,
    RD_DATA,
    RD_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  guard_q, guard_d;
  logic [24:0] addr_q, addr_d;
  logic [9:0]  len_q, len_d;
  logic [9:0]  ack_cnt_q, ack_cnt_d;
  logic [9:0]  xfer_cnt_q, xfer_cnt_d;
  logic [9:0]  rd_cnt_q, rd_cnt_d;
  logic        ack_prev_q, ack_prev_d;
  logic        hold_vld_q, hold_vld_d;
  logic [31:0] hold_q, hold_d;
  logic        rd_ack_q, rd_ack_d;
  logic [31:0] dout_q, dout_d;

  logic        wr_xfer;
  logic        wr_ack;
  logic        rd_cap;

  assign wr_xfer = hold_vld_q & mem_wdata_ready;

  // Ack only if the holding register will be free when the word arrives next cycle.
  assign wr_ack = (state_q == WR_DATA) &&
                  (ack_cnt_q != len_q) &&
                  !ack_prev_q &&
                  (!hold_vld_q || mem_wdata_ready);

  assign rd_cap = (state_q == RD_DATA) &&
                  mem_rdata_valid &&
                  (rd_cnt_q != len_q);

  always_comb begin
    state_d    = state_q;
    guard_d    = guard_q;
    addr_d     = addr_q;
    len_d      = len_q;
    ack_cnt_d  = ack_cnt_q;
    xfer_cnt_d = xfer_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    ack_prev_d = wr_ack;
    hold_vld_d = hold_vld_q;
    hold_d     = hold_q;
    rd_ack_d   = 1'b0;
    dout_d     = dout_q;

    if (wr_xfer) begin
      hold_vld_d = 1'b0;
      xfer_cnt_d = xfer_cnt_q + 10'd1;
    end
    if (ack_prev_q) begin
      hold_vld_d = 1'b1;
      hold_d     = ddr_din;
    end
    if (wr_ack) begin
      ack_cnt_d = ack_cnt_q + 10'd1;
    end
    if (rd_cap) begin
      dout_d   = mem_rdata;
      rd_ack_d = 1'b1;
      rd_cnt_d = rd_cnt_q + 10'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (guard_q != 2'd0) begin
          guard_d = guard_q - 2'd1;
        end else if (ddr_init_done) begin
          if (ddr_wr_req && (wr_length != 10'd0)) begin
            state_d    = WR_CMD;
            addr_d     = ddr_wraddr;
            len_d      = wr_length;
            ack_cnt_d  = 10'd0;
            xfer_cnt_d = 10'd0;
            hold_vld_d = 1'b0;
          end else if (ddr_rd_req && (rd_length != 10'd0)) begin
            state_d  = RD_CMD;
            addr_d   = ddr_rdaddr;
            len_d    = rd_length;
            rd_cnt_d = 10'd0;
          end
        end
      end
      WR_CMD: begin
        if (mem_cmd_ready) state_d = WR_DATA;
      end
      WR_DATA: begin
        if (xfer_cnt_d == len_q) state_d = WR_DONE;
      end
      WR_DONE: begin
        state_d = IDLE;
        guard_d = 2'd2;
      end
      RD_CMD: begin
        if (mem_cmd_ready) state_d = RD_DATA;
      end
      RD_DATA: begin
        // The last word's ack is visible this cycle once the count is full.
        if (rd_cnt_q == len_q) state_d = RD_DONE;
      end
      RD_DONE: begin
        state_d = IDLE;
        guard_d = 2'd2;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      guard_q    <= 2'd0;
      addr_q     <= 25'd0;
      len_q      <= 10'd0;
      ack_cnt_q  <= 10'd0;
      xfer_cnt_q <= 10'd0;
      rd_cnt_q   <= 10'd0;
      ack_prev_q <= 1'b0;
      hold_vld_q <= 1'b0;
      hold_q     <= 32'd0;
      rd_ack_q   <= 1'b0;
      dout_q     <= 32'd0;
    end else begin
      state_q    <= state_d;
      guard_q    <= guard_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      ack_cnt_q  <= ack_cnt_d;
      xfer_cnt_q <= xfer_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      ack_prev_q <= ack_prev_d;
      hold_vld_q <= hold_vld_d;
      hold_q     <= hold_d;
      rd_ack_q   <= rd_ack_d;
      dout_q     <= dout_d;
    end
  end

  assign ddr_wr_ack      = wr_ack;
  assign ddr_rd_ack      = rd_ack_q;
  assign ddr_dout        = dout_q;
  assign ddr_wr_finish   = (state_q == WR_DONE);
  assign ddr_rd_finish   = (state_q == RD_DONE);
  assign mem_cmd_valid   = (state_q == WR_CMD) || (state_q == RD_CMD);
  assign mem_cmd_we      = (state_q == WR_CMD);
  assign mem_cmd_addr    = addr_q;
  assign mem_cmd_len     = len_q;
  assign mem_wdata_valid = hold_vld_q;
  assign mem_wdata       = hold_q;
  assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_ddr_burst_arbiter.sv
// Directed bench for ddr_burst_arbiter: write/read bursts, priority and guard,
// backpressure, mid-burst reset, zero length and init gating.
module tb_ddr_burst_arbiter;

  logic        clk_ref = 1'b0;
  logic        rst = 1'b1;
  logic        ddr_init_done = 1'b0;
  logic        ddr_wr_req = 1'b0;
  logic        ddr_rd_req = 1'b0;
  logic [24:0] ddr_wraddr = '0;
  logic [24:0] ddr_rdaddr = '0;
  logic [9:0]  wr_length = '0;
  logic [9:0]  rd_length = '0;
  logic        ddr_wr_ack;
  logic [31:0] ddr_din = '0;
  logic        ddr_rd_ack;
  logic [31:0] ddr_dout;
  logic        ddr_wr_finish;
  logic        ddr_rd_finish;
  logic        mem_cmd_valid;
  logic        mem_cmd_ready = 1'b1;
  logic        mem_cmd_we;
  logic [24:0] mem_cmd_addr;
  logic [9:0]  mem_cmd_len;
  logic        mem_wdata_valid;
  logic        mem_wdata_ready = 1'b1;
  logic [31:0] mem_wdata;
  logic        mem_rdata_valid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        busy;

  ddr_burst_arbiter dut (
    .clk_ref(clk_ref),
    .rst(rst),
    .ddr_init_done(ddr_init_done),
    .ddr_wr_req(ddr_wr_req),
    .ddr_rd_req(ddr_rd_req),
    .ddr_wraddr(ddr_wraddr),
    .ddr_rdaddr(ddr_rdaddr),
    .wr_length(wr_length),
    .rd_length(rd_length),
    .ddr_wr_ack(ddr_wr_ack),
    .ddr_din(ddr_din),
    .ddr_rd_ack(ddr_rd_ack),
    .ddr_dout(ddr_dout),
    .ddr_wr_finish(ddr_wr_finish),
    .ddr_rd_finish(ddr_rd_finish),
    .mem_cmd_valid(mem_cmd_valid),
    .mem_cmd_ready(mem_cmd_ready),
    .mem_cmd_we(mem_cmd_we),
    .mem_cmd_addr(mem_cmd_addr),
    .mem_cmd_len(mem_cmd_len),
    .mem_wdata_valid(mem_wdata_valid),
    .mem_wdata_ready(mem_wdata_ready),
    .mem_wdata(mem_wdata),
    .mem_rdata_valid(mem_rdata_valid),
    .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 clk_ref = ~clk_ref;

  int total = 0;
  int bad = 0;

  int n_cmd = 0, n_beat = 0, n_wack = 0, n_rack = 0;
  int n_wfin = 0, n_rfin = 0, n_b2b = 0, n_both = 0, n_lat = 0;
  logic        c_we = 1'b0;
  logic [24:0] c_addr = '0;
  logic [9:0]  c_len = '0;
  logic [31:0] beats [0:63];
  logic [31:0] rdat [0:63];
  logic        prev_wack = 1'b0;
  logic        prev_rv = 1'b0;

  // Memory-side and FIFO-side observer; also plays the write FIFO on ddr_din.
  always @(negedge clk_ref) begin
    if (mem_cmd_valid && mem_cmd_ready) begin
      n_cmd++;
      c_we = mem_cmd_we;
      c_addr = mem_cmd_addr;
      c_len = mem_cmd_len;
    end
    if (mem_wdata_valid && mem_wdata_ready) begin
      beats[n_beat[5:0]] = mem_wdata;
      n_beat++;
    end
    if (ddr_wr_ack && prev_wack) n_b2b++;
    if (ddr_wr_ack && ddr_rd_ack) n_both++;
    if (ddr_wr_ack) begin
      ddr_din = 32'hCAFE0000 + 32'(n_wack);
      n_wack++;
    end
    if (ddr_rd_ack) begin
      rdat[n_rack[5:0]] = ddr_dout;
      n_rack++;
      if (!prev_rv) n_lat++;
    end
    if (ddr_wr_finish) n_wfin++;
    if (ddr_rd_finish) n_rfin++;
    prev_wack = ddr_wr_ack;
    prev_rv = mem_rdata_valid;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_ref);
    #1;
  endtask

  // which: 0=cmd 1=wfin 2=rfin 3=beat
  task automatic wait_ev(input string tag, input int which, input int target);
    int cur;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_ref);
      #1;
      cur = (which == 0) ? n_cmd : (which == 1) ? n_wfin :
            (which == 2) ? n_rfin : n_beat;
      if (cur >= target) return;
    end
    chk({tag, "_timeout"}, 64'(cur), 64'(target));
  endtask

  task automatic feed(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      mem_rdata_valid = 1'b1;
      mem_rdata = base + 32'(i);
      step();
    end
    mem_rdata_valid = 1'b0;
  endtask

  int c0, w0, b0, r0, wf0, rf0, wa, gap;

  initial begin
    repeat (3) step();
    chk("rst_outs", {busy, mem_cmd_valid, ddr_wr_ack, ddr_rd_ack,
                     ddr_wr_finish, ddr_rd_finish, mem_wdata_valid}, 0);
    chk("rst_dout", ddr_dout, 0);
    rst = 1'b0;
    ddr_init_done = 1'b1;
    step();

    // Write burst of 4
    c0 = n_cmd; w0 = n_wack; b0 = n_beat; wf0 = n_wfin;
    ddr_wraddr = 25'h100; wr_length = 10'd4; ddr_wr_req = 1'b1;
    wait_ev("wr1", 1, wf0 + 1);
    ddr_wr_req = 1'b0;
    chk("wr1_cmds", n_cmd - c0, 1);
    chk("wr1_cmd", {c_we, c_addr, c_len}, {1'b1, 25'h100, 10'd4});
    chk("wr1_acks", n_wack - w0, 4);
    chk("wr1_beats", n_beat - b0, 4);
    for (int k = 0; k < 4; k++)
      chk("wr1_data", beats[6'(b0 + k)], 32'hCAFE0000 + 32'(w0 + k));
    step();
    chk("wr1_fin", n_wfin - wf0, 1);
    chk("guard_idle1", busy, 0);
    step();
    chk("guard_idle2", busy, 0);

    // Read burst of 3 with a gap between words
    repeat (3) step();
    c0 = n_cmd; r0 = n_rack; rf0 = n_rfin;
    ddr_rdaddr = 25'h200; rd_length = 10'd3; ddr_rd_req = 1'b1;
    wait_ev("rd1_cmd", 0, c0 + 1);
    step();
    feed(1, 32'h1111_0000);
    step();
    feed(2, 32'h1111_0001);
    ddr_rd_req = 1'b0;
    wait_ev("rd1", 2, rf0 + 1);
    chk("rd1_cmd", {c_we, c_addr, c_len}, {1'b0, 25'h200, 10'd3});
    chk("rd1_acks", n_rack - r0, 3);
    for (int k = 0; k < 3; k++)
      chk("rd1_data", rdat[6'(r0 + k)], 32'h1111_0000 + 32'(k));
    step();
    feed(1, 32'hDEAD_BEEF);
    repeat (3) step();
    chk("rd_discard", n_rack - r0, 3);
    chk("rd1_fin", n_rfin - rf0, 1);

    // Priority: write first, read after guard once wr_req drops
    c0 = n_cmd; wf0 = n_wfin; rf0 = n_rfin;
    ddr_wraddr = 25'h300; wr_length = 10'd2;
    ddr_rdaddr = 25'h400; rd_length = 10'd1;
    ddr_wr_req = 1'b1; ddr_rd_req = 1'b1;
    wait_ev("pri_cmd", 0, c0 + 1);
    chk("pri_first", {c_we, c_addr}, {1'b1, 25'h300});
    wait_ev("pri_wr", 1, wf0 + 1);
    ddr_wr_req = 1'b0;
    gap = 0;
    for (int i = 0; i < 10 && !mem_cmd_valid; i++) begin
      step();
      gap++;
    end
    chk("guard_gap", gap, 4);
    wait_ev("pri_rdcmd", 0, c0 + 2);
    chk("pri_second", {c_we, c_addr, c_len}, {1'b0, 25'h400, 10'd1});
    step();
    feed(1, 32'h2222_0000);
    ddr_rd_req = 1'b0;
    wait_ev("pri_rd", 2, rf0 + 1);
    repeat (4) step();

    // Backpressure: wdata_ready low for 5 cycles mid-burst
    c0 = n_cmd; w0 = n_wack; b0 = n_beat; wf0 = n_wfin;
    ddr_wraddr = 25'h500; wr_length = 10'd6; ddr_wr_req = 1'b1;
    wait_ev("bp_beat", 3, b0 + 2);
    wa = n_wack;
    step();
    mem_wdata_ready = 1'b0;
    repeat (5) step();
    chk("bp_noack", n_wack - wa, 0);
    chk("bp_hold", mem_wdata_valid, 1);
    mem_wdata_ready = 1'b1;
    wait_ev("bp", 1, wf0 + 1);
    ddr_wr_req = 1'b0;
    chk("bp_acks", n_wack - w0, 6);
    chk("bp_beats", n_beat - b0, 6);
    for (int k = 0; k < 6; k++)
      chk("bp_data", beats[6'(b0 + k)], 32'hCAFE0000 + 32'(w0 + k));
    repeat (4) step();

    // Mid-burst reset during a read of 8
    c0 = n_cmd; r0 = n_rack; rf0 = n_rfin;
    ddr_rdaddr = 25'h600; rd_length = 10'd8; ddr_rd_req = 1'b1;
    wait_ev("mr_cmd", 0, c0 + 1);
    step();
    feed(2, 32'h3333_0000);
    step();
    chk("mr_two", n_rack - r0, 2);
    rst = 1'b1;
    #1;
    chk("mr_outs", {busy, mem_cmd_valid, ddr_rd_ack, ddr_wr_ack,
                    ddr_rd_finish, ddr_wr_finish, mem_wdata_valid}, 0);
    chk("mr_dout", ddr_dout, 0);
    chk("mr_addr", mem_cmd_addr, 0);
    ddr_rdaddr = 25'h700; rd_length = 10'd2;
    repeat (3) step();
    chk("mr_nofin", n_rfin - rf0, 0);
    r0 = n_rack; c0 = n_cmd;
    rst = 1'b0;
    step();
    chk("post_rst_grant", {mem_cmd_valid, mem_cmd_we, mem_cmd_addr},
        {1'b1, 1'b0, 25'h700});
    wait_ev("pr_cmd", 0, c0 + 1);
    step();
    feed(2, 32'h4444_0000);
    ddr_rd_req = 1'b0;
    wait_ev("pr", 2, rf0 + 1);
    chk("pr_acks", n_rack - r0, 2);
    chk("pr_data0", rdat[6'(r0)], 32'h4444_0000);
    chk("pr_data1", rdat[6'(r0 + 1)], 32'h4444_0001);
    repeat (4) step();

    // Zero length and init gating
    c0 = n_cmd;
    wr_length = 10'd0; ddr_wr_req = 1'b1;
    repeat (10) step();
    chk("zero_len", n_cmd - c0, 0);
    chk("zero_busy", busy, 0);
    ddr_init_done = 1'b0;
    wr_length = 10'd4; ddr_rd_req = 1'b1;
    repeat (10) step();
    chk("no_init", n_cmd - c0, 0);
    chk("no_init_busy", busy, 0);
    ddr_wr_req = 1'b0; ddr_rd_req = 1'b0;
    step();

    chk("ack_b2b", n_b2b, 0);
    chk("ack_both", n_both, 0);
    chk("rd_latency", n_lat, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ddr_burst_arbiter.md
DDR_BURST_ARBITER -- requirements
Module: ddr_burst_arbiter

Interface
REQ-001 SHALL use one clock and an asynchronous active-high reset, with the ports listed in REQ-002 to REQ-007.
REQ-002 clk_ref in 1: clock for all logic; rst in 1: asynchronous active-high reset; ddr_init_done in 1: memory ready, gates new grants.
REQ-003 ddr_wr_req in 1; ddr_rd_req in 1: burst requests from the FIFO controller (level, not pulse).
REQ-004 ddr_wraddr in 25; ddr_rdaddr in 25; wr_length in 10; rd_length in 10: burst start address and word count per direction.
REQ-005 ddr_wr_ack out 1: write-FIFO read strobe, one per word; ddr_din in 32: write word, valid the cycle after its ddr_wr_ack.
REQ-006 ddr_rd_ack out 1: read-FIFO write strobe, one per word; ddr_dout out 32: read word, valid with ddr_rd_ack; ddr_wr_finish out 1, ddr_rd_finish out 1: one-cycle burst-complete pulses.
REQ-007 Memory port signals: mem_cmd_valid out 1; mem_cmd_ready in 1; mem_cmd_we out 1 (1=write); mem_cmd_addr out 25; mem_cmd_len out 10; mem_wdata_valid out 1; mem_wdata_ready in 1; mem_wdata out 32; mem_rdata_valid in 1; mem_rdata in 32; busy out 1 (state != IDLE).

Function
REQ-008 FSM states SHALL be IDLE, WR_CMD, WR_DATA, WR_DONE, RD_CMD, RD_DATA, RD_DONE.
REQ-009 IDLE SHALL grant only when ddr_init_done=1 and guard counter=0; write SHALL win over read when both are asserted.
REQ-010 A request whose length is 0 SHALL be ignored; the FSM stays in IDLE and no ack or finish is produced.
REQ-011 On grant, the address and length SHALL be latched into cmd registers; later changes to ddr_wraddr/ddr_rdaddr/length SHALL NOT affect the burst in flight.
REQ-012 WR_CMD/RD_CMD SHALL hold mem_cmd_valid=1 with stable we/addr/len until mem_cmd_ready=1; the handshake cycle SHALL move to WR_DATA/RD_DATA.
REQ-013 WR_DATA SHALL keep a one-word holding register feeding mem_wdata/mem_wdata_valid; a word is transferred when valid and ready are both 1.
REQ-014 ddr_wr_ack SHALL assert only when all of these hold: issued-ack count < length; no ack was issued in the previous cycle; holding register is empty or is transferring this cycle.
REQ-015 The holding register SHALL load ddr_din in the cycle after each ddr_wr_ack; maximum write throughput is therefore 1 word per 2 cycles.
REQ-016 WR_DATA SHALL move to WR_DONE when the transferred-word count reaches length.
REQ-017 RD_DATA SHALL register each mem_rdata_valid word into ddr_dout and pulse ddr_rd_ack one cycle later (1-cycle latency), with no backpressure.
REQ-018 RD_DATA SHALL move to RD_DONE once the length-th word has been forwarded; mem_rdata_valid outside RD_DATA SHALL be discarded.
REQ-019 WR_DONE/RD_DONE SHALL pulse ddr_wr_finish/ddr_rd_finish for exactly one cycle, then return to IDLE and load the guard counter with 2.
REQ-020 The guard counter SHALL decrement to 0 in IDLE, blocking re-grant on a stale request level.
REQ-021 Word counters SHALL be 10 bits, compared with == against the latched length; no wrap-around is possible because length ≤ 1023.
REQ-022 ddr_init_done deasserting mid-burst SHALL NOT abort the burst; it blocks only new grants.
REQ-023 ddr_wr_ack and ddr_rd_ack SHALL never both assert in the same cycle, and at most one burst SHALL be active at a time.

Reset
REQ-024 While rst=1, the FSM SHALL be in IDLE and all outputs, counters and holding registers SHALL be 0, including mid-burst; the partial burst is abandoned with no finish pulse.
REQ-025 After rst deasserts, the guard counter SHALL be 0 and grants SHALL be possible on the next cycle.

Verification
REQ-026 Write burst: wr_req=1, wraddr=0x100, wr_length=4, cmd_ready and wdata_ready tied 1 -> one cmd (we=1, addr=0x100, len=4); exactly 4 acks in alternate cycles; 4 data beats in ddr_din order; one ddr_wr_finish.
REQ-027 Read burst: rd_req=1, rdaddr=0x200, rd_length=3, rdata_valid on 3 cycles -> cmd we=0, len=3; 3 ddr_rd_ack pulses each 1 cycle after rdata_valid with matching data; one ddr_rd_finish.
REQ-028 Priority and guard: wr_req and rd_req both held 1 -> write granted first; after wr_finish there are ≥2 idle cycles, and a read is granted only if wr_req has dropped.
REQ-029 Backpressure: wdata_ready=0 for 5 cycles mid-burst -> no further ddr_wr_ack while the holding register is full; no data lost or duplicated; word count stays exact.
REQ-030 Mid-burst reset: rst pulsed during RD_DATA after 2 of 8 words -> all outputs 0 immediately; no finish pulse; a fresh request afterwards completes normally.
REQ-031 Zero and init: wr_length=0 with wr_req=1 -> no cmd; ddr_init_done=0 with requests asserted -> no cmd.
